// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings, PC step,
// default reset PC, instruction width and a saturating counter helper.
package if_fetch_unit_pkg;

    localparam int unsigned INST_W           = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [0:0] FS_FETCH   = 1'b0;
    localparam logic [0:0] FS_DISCARD = 1'b1;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/if_fetch_unit_queue.sv
// fetch_queue: synchronous circular FIFO holding {inst, pc} pairs; flush beats push.
module fetch_queue
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned W      = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             head_data,
    output logic [$clog2(QDEPTH):0]  count
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop    = pop && (count != '0);
    assign do_push   = push && ((count != CW'(QDEPTH)) || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC owner, single-outstanding ROM requester, decode queue.
// Optional statistics counters are enabled by defining IF_FETCH_STAT_EN.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    output logic              irom_req,
    output logic [31:0]       irom_addr,
    input  logic              irom_ack,
    input  logic [INST_W-1:0] irom_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       inst_pc,
    input  logic              inst_ready,
    input  logic              redir_valid,
    input  logic [31:0]       redir_pc
`ifdef IF_FETCH_STAT_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_squashed,
    output logic [31:0]       stat_stall
`endif
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    logic [0:0]          fsm;
    logic [0:0]          fsm_nxt;
    logic [31:0]         pc;
    logic [31:0]         pc_nxt;
    logic [31:0]         target;
    logic                ack_fire;
    logic                push;
    logic                pop;
    logic                flush;
    logic                busy_next;
    logic                issue;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_next;
    logic [INST_W+31:0]  head;

    assign ack_fire   = irom_req & irom_ack;
    assign target     = redir_pc & 32'hFFFF_FFFC;
    assign flush      = redir_valid;
    assign push       = ack_fire & (fsm == FS_FETCH) & ~redir_valid;
    assign pop        = inst_valid & inst_ready;
    assign inst_valid = (count != '0);
    assign inst       = head[INST_W+31:32];
    assign inst_pc    = head[31:0];

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .W      (INST_W + 32)
    ) u_queue (
        .clk       (cpu_clk),
        .rst       (cpu_rst),
        .push      (push),
        .push_data ({irom_rdata, irom_addr}),
        .pop       (pop),
        .flush     (flush),
        .head_data (head),
        .count     (count)
    );

    // Credit is judged on the post-edge occupancy so a push and a new request
    // can coincide, sustaining one word per cycle against a zero-wait ROM.
    always_comb begin
        pc_nxt = pc;
        if (redir_valid) begin
            pc_nxt = target;
        end else if (push) begin
            pc_nxt = irom_addr + PC_INC;
        end

        busy_next = irom_req & ~irom_ack;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end
        issue = ~busy_next & (count_next < CW'(QDEPTH));

        fsm_nxt = fsm;
        if (fsm == FS_FETCH) begin
            if (redir_valid && busy_next) begin
                fsm_nxt = FS_DISCARD;
            end
        end else if (ack_fire) begin
            fsm_nxt = FS_FETCH;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            fsm       <= FS_FETCH;
            pc        <= RESET_PC;
            irom_req  <= 1'b0;
            irom_addr <= RESET_PC;
        end else begin
            fsm <= fsm_nxt;
            pc  <= pc_nxt;
            if (issue) begin
                irom_req  <= 1'b1;
                irom_addr <= pc_nxt;
            end else if (!busy_next) begin
                irom_req <= 1'b0;
            end
        end
    end

`ifdef IF_FETCH_STAT_EN
    logic [31:0] squash_inc;

    // Entries popped during a redirect were consumed by decode, not squashed.
    always_comb begin
        squash_inc = 32'(ack_fire & ((fsm == FS_DISCARD) | redir_valid));
        if (flush) begin
            squash_inc = squash_inc + 32'(count - CW'(pop));
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            stat_fetched  <= '0;
            stat_squashed <= '0;
            stat_stall    <= '0;
        end else begin
            stat_fetched  <= sat_add32(stat_fetched, 32'(push));
            stat_squashed <= sat_add32(stat_squashed, squash_inc);
            stat_stall    <= sat_add32(stat_stall, 32'(inst_valid & ~inst_ready));
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized
// ROM latency, decode back-pressure and redirects against a PC-stream model.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        irom_req;
    logic [31:0] irom_addr;
    logic        irom_ack;
    logic [31:0] irom_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redir_valid;
    logic [31:0] redir_pc;
`ifdef IF_FETCH_STAT_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_squashed;
    logic [31:0] stat_stall;
`endif

    if_fetch_unit #(
        .RESET_PC (RST_PC),
        .QDEPTH   (2)
    ) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .irom_req    (irom_req),
        .irom_addr   (irom_addr),
        .irom_ack    (irom_ack),
        .irom_rdata  (irom_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc)
`ifdef IF_FETCH_STAT_EN
        ,
        .stat_fetched  (stat_fetched),
        .stat_squashed (stat_squashed),
        .stat_stall    (stat_stall)
`endif
    );

    always #5 cpu_clk = ~cpu_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          acks     = 0;
    logic        rst_v    = 1'b1;
    logic        spur_en  = 1'b0;
    logic        force_ack = 1'b0;
    logic        rand_lat = 1'b0;
    int unsigned lat      = 0;
    int unsigned wait_c   = 0;
    logic        pend     = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] exp_pc   = RST_PC;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Called at a falling edge: checks outputs, drives this cycle's inputs,
    // advances the delivered-PC model, then moves to the next falling edge.
    task automatic cycle(input logic rdy, input logic rd, input logic [31:0] tgt);
        cpu_rst     = rst_v;
        inst_ready  = rdy;
        redir_valid = rd;
        redir_pc    = tgt;
        if (rst_v) begin
            irom_ack   = 1'b0;
            irom_rdata = $urandom;
            exp_pc     = RST_PC;
            wait_c     = 0;
            pend       = 1'b0;
        end else begin
            if (pend) begin
                check_eq("hold_req", 32'(irom_req), 32'd1);
                check_eq("hold_addr", irom_addr, pend_addr);
            end
            if (irom_req) irom_ack = (wait_c >= lat);
            else          irom_ack = force_ack || (spur_en && ($urandom_range(0, 9) == 0));
            irom_rdata = (irom_req && irom_ack) ? rom_word(irom_addr) : $urandom;
            pend      = irom_req && !irom_ack;
            pend_addr = irom_addr;
            if (irom_req && irom_ack) begin
                acks++;
                wait_c = 0;
                if (rand_lat) lat = $urandom_range(0, 3);
            end else if (irom_req) begin
                wait_c++;
            end
            if (inst_valid && rdy) begin
                check_eq("pop_pc", inst_pc, exp_pc);
                check_eq("pop_inst", inst, rom_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            if (rd) exp_pc = tgt & 32'hFFFF_FFFC;
        end
        @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    task automatic do_reset(input int unsigned n);
        rst_v = 1'b1;
        repeat (n) cycle(1'b1, 1'b0, '0);
        rst_v = 1'b0;
    endtask

    initial begin
        cpu_rst = 1'b1; irom_ack = 1'b0; irom_rdata = '0;
        inst_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
        @(negedge cpu_clk);

        // Reset state, then zero-wait streaming.
        lat = 0;
        do_reset(3);
        check_eq("rst_req", 32'(irom_req), 32'd0);
        check_eq("rst_addr", irom_addr, RST_PC);
        check_eq("rst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_inst", inst, 32'd0);
        check_eq("rst_inst_pc", inst_pc, 32'd0);
        cycle(1'b1, 1'b0, '0);
        check_eq("zw_req", 32'(irom_req), 32'd1);
        check_eq("zw_addr", irom_addr, RST_PC);
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            check_eq("zw_valid", 32'(inst_valid), 32'd1);
            check_eq("zw_pc", inst_pc, 32'(i * 4));
            cycle(1'b1, 1'b0, '0);
        end

        // Decode stalled: credit limits accepted acks to the queue depth.
        do_reset(2);
        acks = 0;
        repeat (7) cycle(1'b0, 1'b0, '0);
        check_eq("stall_acks_le_depth", 32'(acks <= 2), 32'd1);
        check_eq("stall_req_low", 32'(irom_req), 32'd0);
        check_eq("stall_valid", 32'(inst_valid), 32'd1);
        check_eq("stall_head", inst_pc, 32'h0);
        cycle(1'b1, 1'b0, '0);
        check_eq("resume_pc", inst_pc, 32'h4);
        repeat (6) cycle(1'b1, 1'b0, '0);

        // 3-cycle ROM, redirect on the second wait cycle.
        lat = 3;
        do_reset(2);
        cycle(1'b1, 1'b0, '0);
        check_eq("lat_req", 32'(irom_req), 32'd1);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h0000_0100);
        check_eq("disc_addr_n3", irom_addr, 32'h0);
        check_eq("disc_valid_n3", 32'(inst_valid), 32'd0);
        cycle(1'b1, 1'b0, '0);
        check_eq("disc_addr_n4", irom_addr, 32'h0);
        cycle(1'b1, 1'b0, '0);
        check_eq("disc_new_req", 32'(irom_req), 32'd1);
        check_eq("disc_new_addr", irom_addr, 32'h100);
        check_eq("disc_valid", 32'(inst_valid), 32'd0);
        lat = 0;
        repeat (8) cycle(1'b1, 1'b0, '0);

        // Redirect coincident with an ack.
        check_eq("coin_req_pre", 32'(irom_req), 32'd1);
        cycle(1'b1, 1'b1, 32'h0000_0043);
        check_eq("coin_addr", irom_addr, 32'h40);
        check_eq("coin_valid", 32'(inst_valid), 32'd0);
        repeat (4) cycle(1'b1, 1'b0, '0);

        // PC wrap.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        check_eq("wrap_addr", irom_addr, 32'hFFFF_FFFC);
        check_eq("wrap_valid0", 32'(inst_valid), 32'd0);
        cycle(1'b1, 1'b0, '0);
        check_eq("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, '0);
        check_eq("wrap_pc1", inst_pc, 32'h0000_0000);
        repeat (4) cycle(1'b1, 1'b0, '0);

        // Reset while a request is pending; a late ack must be ignored.
        lat = 3;
        do_reset(2);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        rst_v = 1'b1;
        cycle(1'b1, 1'b0, '0);
        rst_v = 1'b0;
        check_eq("mid_rst_req", 32'(irom_req), 32'd0);
        check_eq("mid_rst_valid", 32'(inst_valid), 32'd0);
`ifdef IF_FETCH_STAT_EN
        check_eq("stat_fetched_rst", stat_fetched, 32'd0);
        check_eq("stat_squashed_rst", stat_squashed, 32'd0);
        check_eq("stat_stall_rst", stat_stall, 32'd0);
`endif
        force_ack = 1'b1;
        cycle(1'b1, 1'b0, '0);
        force_ack = 1'b0;
        check_eq("restart_req", 32'(irom_req), 32'd1);
        check_eq("restart_addr", irom_addr, RST_PC);
        repeat (12) cycle(1'b1, 1'b0, '0);

        // Randomized latency, back-pressure, redirects and stray acks.
        rand_lat = 1'b1;
        spur_en  = 1'b1;
        do_reset(2);
        for (int i = 0; i < 1500; i++) begin
            logic        rdy;
            logic        rd;
            logic [31:0] tgt;
            rdy = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 24) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            cycle(rdy, rd, tgt);
        end
        spur_en = 1'b0;
        repeat (20) cycle(1'b1, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
